// File: rtl/div_hilo_ctrl_pkg.sv
// Shared constants for the divide sequencer: default sizing and FSM state encodings.
package div_hilo_ctrl_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_SETTLE = 4;

   // State encodings kept as plain constants so legacy code can compare against them.
   localparam logic STATE_IDLE = 1'b0;
   localparam logic STATE_WAIT = 1'b1;

   // Counter width able to hold SETTLE-1, never narrower than one bit.
   function automatic int cnt_width(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage

// File: rtl/div_hilo_ctrl_if.sv
// Control-unit / datapath signal bundle for the divide sequencer and HI/LO pair.
interface div_hilo_ctrl_if
   import div_hilo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] div_a;
   logic [WIDTH-1:0] div_b;
   logic [WIDTH-1:0] div_res;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] bus_in;
   logic             hi_wr;
   logic             lo_wr;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   // Environment side: control unit plus the Div datapath beside the block.
   modport master (
      output start, op_a, op_b, div_res, div_rem, bus_in, hi_wr, lo_wr,
      input  div_a, div_b, busy, done, dz, hi_out, lo_out
   );

   // Sequencer side.
   modport slave (
      input  start, op_a, op_b, div_res, div_rem, bus_in, hi_wr, lo_wr,
      output div_a, div_b, busy, done, dz, hi_out, lo_out
   );
endinterface

// File: rtl/div_hilo_ctrl_hilo_regs.sv
// HI/LO register pair: synchronous clear, divide/fast-path capture, direct bus writes.
module hilo_regs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cap_en,
   input  logic [WIDTH-1:0] cap_hi,
   input  logic [WIDTH-1:0] cap_lo,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Clear beats capture, capture beats a bus write landing on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (clr) begin
         hi <= '0;
         lo <= '0;
      end else if (cap_en) begin
         hi <= cap_hi;
         lo <= cap_lo;
      end else begin
         if (wr_hi) hi <= bus_in;
         if (wr_lo) lo <= bus_in;
      end
   end

endmodule

// File: rtl/div_hilo_ctrl.sv
// Sequencer around the combinational Div: holds operands for SETTLE cycles, then writes
// quotient to LO and remainder to HI. Divide-by-zero and INT_MIN/-1 resolve in one cycle.
module div_hilo_ctrl
   import div_hilo_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int SETTLE = DEF_SETTLE
) (
   input logic              clk,
   input logic              clr,
   div_hilo_ctrl_if.slave   bus
);

   localparam int               CNT_W   = cnt_width(SETTLE);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic             state;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic             dz_q;
   logic [WIDTH-1:0] div_a_q;
   logic [WIDTH-1:0] div_b_q;

   logic             b_zero;
   logic             ovf;
   logic             fast;
   logic             capture_div;
   logic             cap_en;
   logic [WIDTH-1:0] cap_hi;
   logic [WIDTH-1:0] cap_lo;
   logic             idle;

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.dz    = dz_q;
   assign bus.div_a = div_a_q;
   assign bus.div_b = div_b_q;
   assign idle      = (state == STATE_IDLE);

   // Special-case detection and selection of the value written into HI/LO.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      b_zero      = (bus.op_b == '0);
      ovf         = (bus.op_a == INT_MIN) && (bus.op_b == '1);
      fast        = idle && bus.start && (b_zero || ovf);
      capture_div = (state == STATE_WAIT) && (cnt == '0);
      cap_en      = fast || capture_div;
      cap_lo      = bus.div_res;
      cap_hi      = bus.div_rem;
      if (fast && b_zero) begin
         cap_lo = '1;
         cap_hi = bus.op_a;
      end else if (fast) begin
         cap_lo = INT_MIN;
         cap_hi = '0;
      end
   end

   // FSM: accept a start in IDLE, count down the settle window in WAIT, pulse done.
   always_ff @(posedge clk) begin
      if (clr) begin
         state   <= STATE_IDLE;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         div_a_q <= '0;
         div_b_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (bus.start) begin
                  if (b_zero) begin
                     dz_q   <= 1'b1;
                     done_q <= 1'b1;
                  end else if (ovf) begin
                     dz_q   <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     div_a_q <= bus.op_a;
                     div_b_q <= bus.op_b;
                     cnt     <= CNT_W'(SETTLE - 1);
                     busy_q  <= 1'b1;
                     dz_q    <= 1'b0;
                     state   <= STATE_WAIT;
                  end
               end
            end
            default: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= STATE_IDLE;
               end
            end
         endcase
      end
   end

   hilo_regs #(.WIDTH(WIDTH)) u_hilo (
      .clk    (clk),
      .clr    (clr),
      .cap_en (cap_en),
      .cap_hi (cap_hi),
      .cap_lo (cap_lo),
      .wr_hi  (bus.hi_wr && idle),
      .wr_lo  (bus.lo_wr && idle),
      .bus_in (bus.bus_in),
      .hi     (bus.hi_out),
      .lo     (bus.lo_out)
   );

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Self-checking bench for div_hilo_ctrl (WIDTH=32, SETTLE=4) with a behavioural Div beside it.
module tb_div_hilo_ctrl;

   localparam int          W       = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dz;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic clr;
   int   n_vec = 0;
   int   n_err = 0;

   div_hilo_ctrl_if #(.WIDTH(W)) u_if ();

   div_hilo_ctrl #(.WIDTH(W), .SETTLE(4)) dut (
      .clk (clk),
      .clr (clr),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   // Behavioural Div datapath; outputs 0 for operand pairs it is never asked to settle.
   always_comb begin
      u_if.div_res = '0;
      u_if.div_rem = '0;
      if (u_if.div_b != '0 && !(u_if.div_a == INT_MIN && u_if.div_b == '1)) begin
         u_if.div_res = $signed(u_if.div_a) / $signed(u_if.div_b);
         u_if.div_rem = $signed(u_if.div_a) % $signed(u_if.div_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one start and follow it until done (bounded); reports done cycle and busy cycles.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_cnt);
      int n;
      u_if.op_a  = a;
      u_if.op_b  = b;
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      n          = 1;
      busy_cnt   = 0;
      while (!u_if.done && n < 20) begin
         if (u_if.busy) busy_cnt++;
         tick();
         n++;
      end
      lat = u_if.done ? n : 0;
   endtask

   vec_t vecs[12];

   initial begin
      int          lat;
      int          bc;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] elo;
      logic [31:0] ehi;
      logic        edz;
      logic        saw_done;

      vecs[0]  = '{"100/7",       32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 5};
      vecs[1]  = '{"-100/7",      -32'sd100,    32'd7,        -32'sd14,     -32'sd2,      1'b0, 5};
      vecs[2]  = '{"100/-7",      32'd100,      -32'sd7,      -32'sd14,     32'd2,        1'b0, 5};
      vecs[3]  = '{"-100/-7",     -32'sd100,    -32'sd7,      32'd14,       -32'sd2,      1'b0, 5};
      vecs[4]  = '{"55/0",        32'd55,       32'd0,        32'hFFFF_FFFF, 32'd55,      1'b1, 1};
      vecs[5]  = '{"9/3",         32'd9,        32'd3,        32'd3,        32'd0,        1'b0, 5};
      vecs[6]  = '{"min/-1",      INT_MIN,      32'hFFFF_FFFF, INT_MIN,     32'd0,        1'b0, 1};
      vecs[7]  = '{"0/5",         32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 5};
      vecs[8]  = '{"7/100",       32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 5};
      vecs[9]  = '{"min/1",       INT_MIN,      32'd1,        INT_MIN,      32'd0,        1'b0, 5};
      vecs[10] = '{"-7/0",        -32'sd7,      32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1};
      vecs[11] = '{"min/2",       INT_MIN,      32'd2,        32'hC000_0000, 32'd0,       1'b0, 5};

      u_if.start   = 1'b0;
      u_if.op_a    = '0;
      u_if.op_b    = '0;
      u_if.bus_in  = '0;
      u_if.hi_wr   = 1'b0;
      u_if.lo_wr   = 1'b0;
      clr          = 1'b1;
      tick();
      tick();
      clr = 1'b0;

      // Reset state.
      check("rst busy",  {31'd0, u_if.busy}, 32'd0);
      check("rst done",  {31'd0, u_if.done}, 32'd0);
      check("rst dz",    {31'd0, u_if.dz},   32'd0);
      check("rst hi",    u_if.hi_out, 32'd0);
      check("rst lo",    u_if.lo_out, 32'd0);
      check("rst div_a", u_if.div_a,  32'd0);
      check("rst div_b", u_if.div_b,  32'd0);

      // Table: back-to-back, each start issued in the done cycle of the previous one.
      for (int i = 0; i < 12; i++) begin
         run_div(vecs[i].a, vecs[i].b, lat, bc);
         check({vecs[i].name, " lat"},  32'(lat), 32'(vecs[i].lat));
         check({vecs[i].name, " busy"}, 32'(bc),  (vecs[i].lat == 1) ? 32'd0 : 32'd4);
         check({vecs[i].name, " lo"},   u_if.lo_out, vecs[i].lo);
         check({vecs[i].name, " hi"},   u_if.hi_out, vecs[i].hi);
         check({vecs[i].name, " dz"},   {31'd0, u_if.dz}, {31'd0, vecs[i].dz});
      end
      tick();
      check("done one cycle", {31'd0, u_if.done}, 32'd0);

      // clr in WAIT cycle 2 aborts: no done, HI/LO cleared.
      u_if.op_a  = 32'd100;
      u_if.op_b  = 32'd7;
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      tick();
      clr = 1'b1;
      tick();
      clr      = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (u_if.done) saw_done = 1'b1;
         tick();
      end
      check("abort no done", {31'd0, saw_done}, 32'd0);
      check("abort busy",    {31'd0, u_if.busy}, 32'd0);
      check("abort hi",      u_if.hi_out, 32'd0);
      check("abort lo",      u_if.lo_out, 32'd0);

      // Second start and lo_wr while busy are ignored.
      u_if.op_a  = 32'd100;
      u_if.op_b  = 32'd7;
      u_if.start = 1'b1;
      tick();
      u_if.start = 1'b0;
      tick();
      u_if.op_a   = 32'd20;
      u_if.op_b   = 32'd3;
      u_if.start  = 1'b1;
      u_if.lo_wr  = 1'b1;
      u_if.bus_in = 32'hDEAD_BEEF;
      tick();
      u_if.start = 1'b0;
      u_if.lo_wr = 1'b0;
      check("busy div_a held", u_if.div_a, 32'd100);
      check("busy div_b held", u_if.div_b, 32'd7);
      check("busy lo_wr",      u_if.lo_out, 32'd0);
      lat = 0;
      for (int i = 0; i < 20 && lat == 0; i++) begin
         if (u_if.done) lat = 1;
         else tick();
      end
      check("ignored start done", 32'(lat), 32'd1);
      check("ignored start lo",   u_if.lo_out, 32'd14);
      check("ignored start hi",   u_if.hi_out, 32'd2);
      tick();
      check("ignored start idle", {31'd0, u_if.busy}, 32'd0);

      // Idle bus writes.
      u_if.hi_wr  = 1'b1;
      u_if.bus_in = 32'h1234;
      tick();
      u_if.hi_wr = 1'b0;
      check("hi_wr", u_if.hi_out, 32'h1234);
      u_if.lo_wr  = 1'b1;
      u_if.bus_in = 32'h5678;
      tick();
      u_if.lo_wr = 1'b0;
      check("lo_wr", u_if.lo_out, 32'h5678);

      // Fast-path result wins over a same-edge hi_wr.
      u_if.hi_wr  = 1'b1;
      u_if.bus_in = 32'hABCD;
      u_if.op_a   = 32'd55;
      u_if.op_b   = 32'd0;
      u_if.start  = 1'b1;
      tick();
      u_if.start = 1'b0;
      u_if.hi_wr = 1'b0;
      check("fast vs hi_wr hi", u_if.hi_out, 32'd55);
      check("fast vs hi_wr lo", u_if.lo_out, 32'hFFFF_FFFF);

      // Normal start plus lo_wr on the same edge: write lands, divide overwrites later.
      u_if.lo_wr  = 1'b1;
      u_if.bus_in = 32'h0BAD;
      u_if.op_a   = 32'd9;
      u_if.op_b   = 32'd3;
      u_if.start  = 1'b1;
      tick();
      u_if.start = 1'b0;
      u_if.lo_wr = 1'b0;
      check("start+lo_wr lo", u_if.lo_out, 32'h0BAD);
      check("start clears dz", {31'd0, u_if.dz}, 32'd0);
      for (int i = 0; i < 20 && !u_if.done; i++) tick();
      check("start+lo_wr result", u_if.lo_out, 32'd3);

      // Random sweep against the signed / and % reference.
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 15))
            0:       rb = '0;
            1:       begin ra = INT_MIN; rb = '1; end
            2:       rb = 32'($urandom_range(1, 9));
            default: ;
         endcase
         if (rb == '0) begin
            elo = 32'hFFFF_FFFF; ehi = ra; edz = 1'b1;
         end else if (ra == INT_MIN && rb == '1) begin
            elo = INT_MIN; ehi = '0; edz = 1'b0;
         end else begin
            elo = $signed(ra) / $signed(rb);
            ehi = $signed(ra) % $signed(rb);
            edz = 1'b0;
         end
         run_div(ra, rb, lat, bc);
         n_vec++;
         if (lat == 0 || u_if.lo_out !== elo || u_if.hi_out !== ehi || u_if.dz !== edz) begin
            n_err++;
            $display("FAIL rand %h/%h: got lo=%h hi=%h dz=%b lat=%0d, expected lo=%h hi=%h dz=%b",
                     ra, rb, u_if.lo_out, u_if.hi_out, u_if.dz, lat, elo, ehi, edz);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
